// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher
//   Collects ALU operation requests into a pending vector (one bit per
//   opcode), picks one pending request, issues its opcode to the ALU over a
//   valid/ready handshake, then waits for the ALU's done pulse (or a
//   timeout) before issuing the next one.
//
//   Build option: define ROUND_ROBIN_EN for round-robin selection. Leave it
//   undefined for fixed priority, where bit 0 is highest.
//
//   Handshake: op_valid rises together with a stable op_code/op_onehot pair.
//   It stays high, with both fields unchanged, until a cycle in which
//   op_ready is also high. That cycle is the transfer. Nothing is withdrawn
//   or replaced while op_valid is high.
//
//   Timing: a req_set pulse in cycle t shows in pending at t+1. The IDLE
//   state samples it there, so op_valid is high at t+2.
//
//   Debug: state_dbg mirrors the FSM state
//   (0 = IDLE, 1 = ISSUE, 2 = WAIT).

module alu_op_dispatcher #(
   parameter int N_REQ    = 16,
   parameter int OPW      = 4,
   parameter int BUSY_MAX = 255,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_set,
   input  logic             op_ready,
   input  logic             alu_done,
   output logic [N_REQ-1:0] pending,
   output logic             op_valid,
   output logic [OPW-1:0]   op_code,
   output logic [N_REQ-1:0] op_onehot,
   output logic             busy,
   output logic             timeout_err,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic             op_valid_q, op_valid_d;
   logic [OPW-1:0]   op_code_q, op_code_d;
   logic [N_REQ-1:0] op_onehot_q, op_onehot_d;
   logic             busy_q, busy_d;
   logic             timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] clr;
   logic             accept;

   // Isolates the lowest set bit (two's-complement trick); zero in, zero out.
   function automatic logic [N_REQ-1:0] lowest_set(input logic [N_REQ-1:0] v);
      return v & (~v + N_REQ'(1));
   endfunction

   // One-hot to index. Undefined for non-one-hot input; callers pass a grant.
   function automatic logic [OPW-1:0] enc_onehot(input logic [N_REQ-1:0] oh);
      logic [OPW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            idx = OPW'(i);
         end
      end
      return idx;
   endfunction

   // A transfer happens only while an opcode is offered and the ALU takes it.
   assign accept = op_valid_q & op_ready;

`ifdef ROUND_ROBIN_EN
   logic [OPW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0] rr_mask;
   logic [N_REQ-1:0] rr_hit;

   // Round-robin pick: the first pending bit above the last grant.
   // Falls back to the lowest pending bit when nothing lies above.
   always_comb begin
      rr_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rr_mask[i] = (i > int'(rr_ptr_q));
      end
      rr_hit = pending_q & rr_mask;
      if (rr_hit != '0) begin
         grant = lowest_set(rr_hit);
      end else begin
         grant = lowest_set(pending_q);
      end
   end

   // The pointer follows the opcode actually accepted, not merely offered.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = op_code_q;
      end
   end

   // Pointer register. Its reset value is the top index, so the first grant
   // after reset matches fixed priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '1;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   // Fixed priority: bit 0 wins; higher bits can starve.
   always_comb begin
      grant = lowest_set(pending_q);
   end
`endif

   // Pending bookkeeping and FSM next-state/next-output logic.
   always_comb begin
      state_d       = state_q;
      op_valid_d    = op_valid_q;
      op_code_d     = op_code_q;
      op_onehot_d   = op_onehot_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = 1'b0;
      clr           = '0;

      // A request that arrives on its own accept cycle survives (set wins).
      if (accept) begin
         clr = op_onehot_q;
      end
      pending_d = (pending_q & ~clr) | req_set;

      unique case (state_q)
         S_IDLE: begin
            // Latch the selection once; it is then frozen until accepted.
            if (pending_q != '0) begin
               op_onehot_d = grant;
               op_code_d   = enc_onehot(grant);
               op_valid_d  = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // No preemption: newer, higher-priority requests just stay queued.
            if (accept) begin
               op_valid_d = 1'b0;
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // wait_cnt_q holds the number of WAIT cycles already elapsed.
            // The last allowed wait cycle is the one that sees BUSY_MAX-1.
            // The dropped operation is not retried.
            if (alu_done) begin
               state_d = S_IDLE;
            end else if (wait_cnt_q == CNT_W'(BUSY_MAX - 1)) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = S_IDLE;
            op_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs. Reset clears everything, queued requests
   // included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pending_q     <= '0;
         op_valid_q    <= 1'b0;
         op_code_q     <= '0;
         op_onehot_q   <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         op_valid_q    <= op_valid_d;
         op_code_q     <= op_code_d;
         op_onehot_q   <= op_onehot_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign pending     = pending_q;
   assign op_valid    = op_valid_q;
   assign op_code     = op_code_q;
   assign op_onehot   = op_onehot_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// tb_alu_op_dispatcher
//   Bench for alu_op_dispatcher. Expected opcodes are queued when requests
//   are driven. Each accepted transfer pops one entry and compares it. A
//   simple ALU model answers accepted operations with a done pulse after a
//   random delay, unless auto_done is cleared.
//   Build with ROUND_ROBIN_EN defined to exercise the round-robin ordering.

module tb_alu_op_dispatcher;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic        clk;
   logic        rst_n;
   logic [15:0] req_set;
   logic        op_ready;
   logic        alu_done;
   logic [15:0] pending;
   logic        op_valid;
   logic [3:0]  op_code;
   logic [15:0] op_onehot;
   logic        busy;
   logic        timeout_err;
   logic [1:0]  state_dbg;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [3:0]  exp_q[$];

   bit          auto_done = 1'b1;
   int          done_cnt  = 0;
   bit          done_go   = 1'b0;
   bit          hold_flag = 1'b0;
   logic [3:0]  held_code;
   logic [3:0]  sb_exp;
   logic [15:0] sb_oh;

   alu_op_dispatcher dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_set     (req_set),
      .op_ready    (op_ready),
      .alu_done    (alu_done),
      .pending     (pending),
      .op_valid    (op_valid),
      .op_code     (op_code),
      .op_onehot   (op_onehot),
      .busy        (busy),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard monitor (samples at negedge) ----------------
   always @(negedge clk) begin
      done_go = 1'b0;
      if (!rst_n) begin
         hold_flag = 1'b0;
         done_cnt  = 0;
      end else begin
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) done_go = 1'b1;
         end
         if (op_valid) begin
            if (hold_flag) check_eq("hold_stable", {28'd0, op_code}, {28'd0, held_code});
            if (op_ready) begin
               hold_flag = 1'b0;
               if (exp_q.size() == 0) begin
                  check_eq("sb_unexpected_issue", {28'd0, op_code}, 32'hFFFF_FFFF);
               end else begin
                  sb_exp = exp_q.pop_front();
                  sb_oh  = 16'd1 << sb_exp;
                  check_eq("sb_code", {28'd0, op_code}, {28'd0, sb_exp});
                  check_eq("sb_onehot", {16'd0, op_onehot}, {16'd0, sb_oh});
               end
               if (auto_done) done_cnt = $urandom_range(1, 4);
            end else begin
               hold_flag = 1'b1;
               held_code = op_code;
            end
         end else begin
            hold_flag = 1'b0;
         end
      end
   end

   // ---------------- ALU done model ----------------
   initial begin
      alu_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         alu_done = done_go;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input logic [15:0] m);
      req_set = m;
      tick();
      req_set = '0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!op_valid && n < 50) begin
         tick();
         n++;
      end
      check_eq(tag, {31'd0, op_valid}, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(state_dbg == ST_IDLE && !op_valid && pending == '0 && exp_q.size() == 0)
             && n < 3000) begin
         tick();
         n++;
      end
      check_eq(tag, {31'd0, (n < 3000)}, 32'd1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic [3:0] rr_seq[7];
   int         wait_n;
   int         guard;

   initial begin
      rst_n    = 1'b0;
      req_set  = '0;
      op_ready = 1'b0;
      repeat (3) tick();

      // Reset values
      check_eq("rst_pending", {16'd0, pending}, 32'd0);
      check_eq("rst_valid", {31'd0, op_valid}, 32'd0);
      check_eq("rst_code", {28'd0, op_code}, 32'd0);
      check_eq("rst_onehot", {16'd0, op_onehot}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_timeout", {31'd0, timeout_err}, 32'd0);
      check_eq("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      rst_n = 1'b1;
      tick();
      check_eq("idle_empty_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      check_eq("idle_empty_valid", {31'd0, op_valid}, 32'd0);

      // Single request: op_valid two cycles after the req_set pulse
      op_ready = 1'b1;
      exp_q.push_back(4'd3);
      pulse_req(16'h0008);
      check_eq("single_pending", {16'd0, pending}, 32'h0008);
      check_eq("single_valid_early", {31'd0, op_valid}, 32'd0);
      tick();
      check_eq("single_valid", {31'd0, op_valid}, 32'd1);
      check_eq("single_code", {28'd0, op_code}, 32'd3);
      check_eq("single_onehot", {16'd0, op_onehot}, 32'h0008);
      tick();
      check_eq("single_pending_clr", {16'd0, pending}, 32'd0);
      check_eq("single_busy", {31'd0, busy}, 32'd1);
      check_eq("single_state_wait", {30'd0, state_dbg}, {30'd0, ST_WAIT});
      wait_idle("single_idle");
      check_eq("single_busy_done", {31'd0, busy}, 32'd0);

      // Priority with backpressure: 8 is held, then 11, 12, 15 follow
      op_ready = 1'b0;
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd11);
      exp_q.push_back(4'd12);
      exp_q.push_back(4'd15);
      pulse_req(16'h9900);
      tick();
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", {31'd0, op_valid}, 32'd1);
         check_eq("bp_code", {28'd0, op_code}, 32'd8);
         check_eq("bp_pending", {16'd0, pending}, 32'h9900);
         tick();
      end
      op_ready = 1'b1;
      tick();
      check_eq("bp_pending_after", {16'd0, pending}, 32'h9800);
      wait_idle("bp_idle");

      // Set/clear collision on the accept cycle: bit 8 stays queued
      op_ready = 1'b0;
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd8);
      pulse_req(16'h0100);
      wait_valid("coll_valid");
      check_eq("coll_code", {28'd0, op_code}, 32'd8);
      op_ready = 1'b1;
      req_set  = 16'h0100;
      tick();
      req_set  = '0;
      check_eq("coll_pending", {16'd0, pending}, 32'h0100);
      wait_idle("coll_idle");

      // Timeout: no done, 255 wait cycles, then a one-cycle error pulse
      auto_done = 1'b0;
      exp_q.push_back(4'd2);
      pulse_req(16'h0004);
      wait_valid("to_valid");
      check_eq("to_code", {28'd0, op_code}, 32'd2);
      tick();
      wait_n = 0;
      guard  = 0;
      while (!timeout_err && guard < 400) begin
         if (busy) wait_n++;
         tick();
         guard++;
      end
      check_eq("to_wait_cycles", wait_n, 32'd255);
      check_eq("to_pulse", {31'd0, timeout_err}, 32'd1);
      check_eq("to_busy", {31'd0, busy}, 32'd0);
      check_eq("to_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      check_eq("to_pending", {16'd0, pending}, 32'd0);
      tick();
      check_eq("to_pulse_end", {31'd0, timeout_err}, 32'd0);
      auto_done = 1'b1;

      // Issue order with 16'h8003. Each accept refills the previously
      // accepted bit, except on the first and last accept.
`ifdef ROUND_ROBIN_EN
      rr_seq = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd15, 4'd0};
`else
      rr_seq = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd15};
`endif
      for (int k = 0; k < 7; k++) exp_q.push_back(rr_seq[k]);
      pulse_req(16'h8003);
      for (int k = 0; k < 6; k++) begin
         wait_valid("order_valid");
         if (k >= 1 && k <= 4) req_set = 16'd1 << rr_seq[k-1];
         tick();
         req_set = '0;
      end
      wait_idle("order_idle");

      // Asynchronous reset in the middle of WAIT, with 16'h00F0 pending
      auto_done = 1'b0;
      exp_q.push_back(4'd0);
      pulse_req(16'h0001);
      wait_valid("arst_valid");
      tick();
      pulse_req(16'h00F0);
      check_eq("arst_pre_pending", {16'd0, pending}, 32'h00F0);
      check_eq("arst_pre_state", {30'd0, state_dbg}, {30'd0, ST_WAIT});
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_pending", {16'd0, pending}, 32'd0);
      check_eq("arst_valid", {31'd0, op_valid}, 32'd0);
      check_eq("arst_code", {28'd0, op_code}, 32'd0);
      check_eq("arst_onehot", {16'd0, op_onehot}, 32'd0);
      check_eq("arst_busy", {31'd0, busy}, 32'd0);
      check_eq("arst_timeout", {31'd0, timeout_err}, 32'd0);
      check_eq("arst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      tick();
      rst_n = 1'b1;
      auto_done = 1'b1;
      tick();
      tick();
      check_eq("arst_lost_pending", {16'd0, pending}, 32'd0);
      check_eq("arst_no_issue", {31'd0, op_valid}, 32'd0);
      check_eq("sb_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
